// File: rtl/param_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : param_register_bank
// Purpose  : Bank of NREG general registers, WIDTH bits each. Eight
//            single-cycle FunSel operations, four bit-serial shift/rotate
//            operations with a Busy/Done handshake, two combinational read
//            ports and Z/C status flags.
// Config   : REGBANK_SATURATE_EN - when defined, inc/dec saturate instead
//            of wrapping; C flags the saturation.
// Ports    : Clock          rising-edge clock
//            Reset          asynchronous active-low reset
//            E              operation request (sampled only when Busy=0)
//            RegSel         destination register
//            FunSel         operation code
//            I              operand / load data; I[log2(WIDTH)-1:0] = shift N
//            RdSelA/RdSelB  read-port selects
//            QA/QB          current contents of the selected registers
//            Busy           multi-cycle shift in progress
//            Done           one-cycle commit pulse
//            Z, C           zero and carry/borrow/shift-out flags
// Revision : 1.0 - initial release
// ============================================================================
module param_register_bank #(
  parameter int WIDTH = 32,
  parameter int NREG  = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    E,
  input  logic [$clog2(NREG)-1:0] RegSel,
  input  logic [3:0]              FunSel,
  input  logic [WIDTH-1:0]        I,
  input  logic [$clog2(NREG)-1:0] RdSelA,
  input  logic [$clog2(NREG)-1:0] RdSelB,
  output logic [WIDTH-1:0]        QA,
  output logic [WIDTH-1:0]        QB,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Z,
  output logic                    C
);

  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREG];
  logic [AW-1:0]    sh_sel;
  logic [1:0]       sh_mode;
  logic [SW-1:0]    sh_cnt;

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] op_val;
  logic             op_c;
  logic signed [15:0]       s16;
  logic signed [WIDTH-1:0]  sext;
  logic [WIDTH-1:0] sh_cur;
  logic [WIDTH-1:0] step_val;
  logic             step_c;

  // Read ports see registered contents, so a same-cycle write reads old data.
  assign QA = regs[RdSelA];
  assign QB = regs[RdSelB];

  assign shamt = I[SW-1:0];

  // Single-cycle operation result and carry for the addressed register.
  always_comb begin
    cur    = regs[RegSel];
    s16    = I[15:0];
    sext   = s16;                 // signed-to-signed widening sign-extends
    op_val = cur;
    op_c   = 1'b0;
    case (FunSel[2:0])
      3'd0: begin
`ifdef REGBANK_SATURATE_EN
        if (cur == '0) begin
          op_val = cur;
          op_c   = 1'b1;
        end else begin
          op_val = cur - WIDTH'(1);
        end
`else
        op_val = cur - WIDTH'(1);
        op_c   = (cur == '0);
`endif
      end
      3'd1: begin
`ifdef REGBANK_SATURATE_EN
        if (&cur) begin
          op_val = cur;
          op_c   = 1'b1;
        end else begin
          op_val = cur + WIDTH'(1);
        end
`else
        op_val = cur + WIDTH'(1);
        op_c   = &cur;
`endif
      end
      3'd2:    op_val = I;
      3'd3:    op_val = '0;
      3'd4:    op_val = WIDTH'(I[7:0]);
      3'd5:    op_val = WIDTH'(I[15:0]);
      3'd6:    op_val = {cur[WIDTH-9:0], I[7:0]};
      default: op_val = sext;
    endcase
  end

  // One bit-serial step of the latched shift on the latched register.
  always_comb begin
    sh_cur = regs[sh_sel];
    case (sh_mode)
      2'd0: begin
        step_val = {sh_cur[WIDTH-2:0], 1'b0};
        step_c   = sh_cur[WIDTH-1];
      end
      2'd1: begin
        step_val = {1'b0, sh_cur[WIDTH-1:1]};
        step_c   = sh_cur[0];
      end
      2'd2: begin
        step_val = {sh_cur[0], sh_cur[WIDTH-1:1]};
        step_c   = sh_cur[0];
      end
      default: begin
        step_val = {sh_cur[WIDTH-1], sh_cur[WIDTH-1:1]};
        step_c   = sh_cur[0];
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
      state   <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Z       <= 1'b0;
      C       <= 1'b0;
      sh_sel  <= '0;
      sh_mode <= '0;
      sh_cnt  <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (E) begin
            if (!FunSel[3]) begin
              regs[RegSel] <= op_val;
              Z            <= (op_val == '0);
              C            <= op_c;
              Done         <= 1'b1;
            end else if (!FunSel[2]) begin
              if (shamt == '0) begin
                // Zero-length shift commits immediately with no shift-out.
                Z    <= (cur == '0);
                C    <= 1'b0;
                Done <= 1'b1;
              end else begin
                state   <= SHIFT;
                Busy    <= 1'b1;
                sh_sel  <= RegSel;
                sh_mode <= FunSel[1:0];
                sh_cnt  <= shamt;
              end
            end
            // 11xx: reserved, nothing happens
          end
        end
        SHIFT: begin
          regs[sh_sel] <= step_val;
          sh_cnt       <= sh_cnt - SW'(1);
          if (sh_cnt == SW'(1)) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            Z     <= (step_val == '0);
            C     <= step_c;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_register_bank
// Purpose  : Self-checking bench for param_register_bank (WIDTH=32, NREG=4).
//            A table of single-cycle operations is applied back to back,
//            followed by hand-written shift, reserved-code and reset
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_register_bank;

  logic        clk;
  logic        rst_n;
  logic        e;
  logic [1:0]  reg_sel;
  logic [3:0]  fun_sel;
  logic [31:0] i_data;
  logic [1:0]  rd_sel_a;
  logic [1:0]  rd_sel_b;
  logic [31:0] qa;
  logic [31:0] qb;
  logic        busy;
  logic        done;
  logic        z;
  logic        c;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model [4];

  param_register_bank #(.WIDTH(32), .NREG(4)) dut (
    .Clock  (clk),
    .Reset  (rst_n),
    .E      (e),
    .RegSel (reg_sel),
    .FunSel (fun_sel),
    .I      (i_data),
    .RdSelA (rd_sel_a),
    .RdSelB (rd_sel_b),
    .QA     (qa),
    .QB     (qb),
    .Busy   (busy),
    .Done   (done),
    .Z      (z),
    .C      (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rsel;
    logic [3:0]  fsel;
    logic [31:0] din;
    logic [31:0] exp_q;
    logic        exp_z;
    logic        exp_c;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a shift request and count the cycles Busy stays high.
  task automatic run_shift(input logic [1:0] rs, input logic [3:0] fs,
                           input logic [31:0] n, output int cycles);
    int guard;
    reg_sel = rs;
    fun_sel = fs;
    i_data  = n;
    e       = 1'b1;
    tick();
    e      = 1'b0;
    cycles = 0;
    guard  = 0;
    while (busy === 1'b1 && guard < 64) begin
      cycles++;
      check("done_low_while_busy", {31'd0, done}, 32'd0);
      tick();
      guard++;
    end
    if (guard >= 64) begin
      n_cmp++;
      n_fail++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, guard);
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] exp_r3;
    logic        exp_c3;

    // ---------------- vector table ----------------
    vecs[0]  = '{2'd1, 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};
`ifdef REGBANK_SATURATE_EN
    vecs[1]  = '{2'd1, 4'b0001, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b1};
`else
    vecs[1]  = '{2'd1, 4'b0001, 32'h0,         32'h0000_0000, 1'b1, 1'b1};
`endif
    vecs[2]  = '{2'd0, 4'b0011, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b0};
`ifdef REGBANK_SATURATE_EN
    vecs[3]  = '{2'd0, 4'b0000, 32'h0,         32'h0000_0000, 1'b1, 1'b1};
`else
    vecs[3]  = '{2'd0, 4'b0000, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b1};
`endif
    vecs[4]  = '{2'd2, 4'b0010, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0};
    vecs[5]  = '{2'd2, 4'b0001, 32'h0,         32'h1234_5679, 1'b0, 1'b0};
    vecs[6]  = '{2'd2, 4'b0000, 32'h0,         32'h1234_5678, 1'b0, 1'b0};
    vecs[7]  = '{2'd3, 4'b0100, 32'hABCD_EF98, 32'h0000_0098, 1'b0, 1'b0};
    vecs[8]  = '{2'd3, 4'b0101, 32'hABCD_EF98, 32'h0000_EF98, 1'b0, 1'b0};
    vecs[9]  = '{2'd3, 4'b0111, 32'hABCD_EF98, 32'hFFFF_EF98, 1'b0, 1'b0};
    vecs[10] = '{2'd3, 4'b0111, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0, 1'b0};
    vecs[11] = '{2'd3, 4'b0110, 32'hFFFF_FF5A, 32'h007F_FF5A, 1'b0, 1'b0};
    vecs[12] = '{2'd2, 4'b0110, 32'h0000_0011, 32'h3456_7811, 1'b0, 1'b0};
    vecs[13] = '{2'd2, 4'b0010, 32'h0000_00F0, 32'h0000_00F0, 1'b0, 1'b0};
    vecs[14] = '{2'd0, 4'b0010, 32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0};

    for (int k = 0; k < 4; k++) model[k] = 32'd0;

    // ---------------- reset ----------------
    rst_n = 1'b0; e = 1'b0; reg_sel = '0; fun_sel = '0; i_data = '0;
    rd_sel_a = '0; rd_sel_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      rd_sel_a = 2'(k);
      #1;
      check("reset_reg", qa, 32'd0);
    end
    check("reset_flags", {28'd0, busy, done, z, c}, 32'd0);

    // ---------------- back-to-back single-cycle ops ----------------
    @(negedge clk);
    e = 1'b1;
    for (int k = 0; k < 15; k++) begin
      reg_sel  = vecs[k].rsel;
      fun_sel  = vecs[k].fsel;
      i_data   = vecs[k].din;
      rd_sel_a = vecs[k].rsel;
      rd_sel_b = vecs[k].rsel;
      #1;
      check($sformatf("v%0d_qb_old", k), qb, model[vecs[k].rsel]);
      tick();
      check($sformatf("v%0d_q", k), qa, vecs[k].exp_q);
      check($sformatf("v%0d_zcdone", k), {29'd0, vecs[k].exp_z, vecs[k].exp_c, 1'b1},
            {29'd0, z, c, done});
      model[vecs[k].rsel] = vecs[k].exp_q;
    end
    e = 1'b0;
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);

    // ---------------- LSL R2 by 4 ----------------
    rd_sel_a = 2'd2;
    run_shift(2'd2, 4'b1000, 32'd4, cyc);
    check("lsl_busy_cycles", 32'(cyc), 32'd4);
    check("lsl_q", qa, 32'h0000_0F00);
    check("lsl_flags", {29'd0, busy, z, c}, 32'd0);
    check("lsl_done", {31'd0, done}, 32'd1);
    tick();
    check("lsl_done_fall", {31'd0, done}, 32'd0);

    // ---------------- ASR R0 by 1, then ROR by 0 ----------------
    rd_sel_a = 2'd0;
    run_shift(2'd0, 4'b1011, 32'd1, cyc);
    check("asr_busy_cycles", 32'(cyc), 32'd1);
    check("asr_q", qa, 32'hC000_0000);
    check("asr_zcdone", {29'd0, z, c, done}, 32'b011);
    reg_sel = 2'd0; fun_sel = 4'b1010; i_data = 32'd0; e = 1'b1;
    tick();
    e = 1'b0;
    check("ror0_q", qa, 32'hC000_0000);
    check("ror0_busy_z_c_done", {28'd0, busy, z, c, done}, 32'b0001);

    // ---------------- LSR R3 by 5, clear attempts ignored ----------------
    rd_sel_a = 2'd3;
    exp_r3   = 32'h007F_FF5A;
    exp_c3   = 1'b0;
    reg_sel = 2'd3; fun_sel = 4'b1001; i_data = 32'd5; e = 1'b1;
    tick();
    fun_sel = 4'b0011; i_data = 32'd0;       // E held high: must be ignored
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("lsr_busy_%0d", k), {31'd0, busy}, 32'd1);
      exp_c3 = exp_r3[0];
      exp_r3 = exp_r3 >> 1;
      if (k == 5) e = 1'b0;
      tick();
      check($sformatf("lsr_q_%0d", k), qa, exp_r3);
    end
    check("lsr_end_busy_done", {30'd0, busy, done}, 32'b01);
    check("lsr_end_zc", {30'd0, z, c}, {30'd0, 1'b0, exp_c3});
    check("lsr_final_const", qa, 32'h0003_FFFA);

    // ---------------- reserved codes ----------------
    reg_sel = 2'd3; fun_sel = 4'b1100; i_data = 32'hFFFF_FFFF; e = 1'b1;
    tick();
    check("rsv_q", qa, 32'h0003_FFFA);
    check("rsv_flags", {28'd0, busy, done, z, c}, 32'b0001);
    fun_sel = 4'b1111;
    tick();
    e = 1'b0;
    check("rsv2_q", qa, 32'h0003_FFFA);
    check("rsv2_flags", {28'd0, busy, done, z, c}, 32'b0001);

    // ---------------- async reset mid-shift ----------------
    rd_sel_a = 2'd2;
    reg_sel = 2'd2; fun_sel = 4'b1000; i_data = 32'd10; e = 1'b1;
    tick();
    e = 1'b0;
    repeat (3) tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    check("pre_reset_q", qa, 32'h0000_7800);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      rd_sel_a = 2'(k);
      #1;
      check("post_reset_reg", qa, 32'd0);
    end
    check("post_reset_flags", {28'd0, busy, done, z, c}, 32'd0);
    tick();
    check("post_reset_idle", {28'd0, busy, done, z, c}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
